// File: rtl/oled_frame_streamer_if.sv
// oled_frame_streamer_if
//   Bundles the control, frame-memory and byte-stream signals of the OLED
//   frame streamer.
//   master modport: streamer side (drives busy/done, memory controls, byte stream).
//   slave modport : environment side (drives start, memory DataOut, byte_ready).
//   Signals:
//     start, busy, done              frame control
//     mem_we_bar, mem_cs_bar,
//     mem_addr, mem_data_in          frame memory read port (lane i = byte i)
//     byte_out, byte_valid,
//     byte_ready, byte_last          valid/ready byte stream to the serial driver
interface oled_frame_streamer_if #(
  parameter int ROWS          = 8,
  parameter int BYTES_PER_ROW = 12
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          mem_we_bar;
  logic                          mem_cs_bar;
  logic [AW-1:0]                 mem_addr;
  logic [BYTES_PER_ROW-1:0][7:0] mem_data_in;
  logic [7:0]                    byte_out;
  logic                          byte_valid;
  logic                          byte_ready;
  logic                          byte_last;

  modport master (
    input  start, mem_data_in, byte_ready,
    output busy, done, mem_we_bar, mem_cs_bar, mem_addr,
           byte_out, byte_valid, byte_last
  );

  modport slave (
    output start, mem_data_in, byte_ready,
    input  busy, done, mem_we_bar, mem_cs_bar, mem_addr,
           byte_out, byte_valid, byte_last
  );
endinterface

// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer
//   Reads a ROWS x BYTES_PER_ROW frame memory one row at a time, latches the
//   row, and streams its bytes in order over a valid/ready byte interface.
//   The memory is read-only from here (WE_bar tied high). The final byte of
//   the frame carries byte_last; a one-cycle done follows its handshake.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - oled_frame_streamer_if.master (control, memory, byte stream)
module oled_frame_streamer #(
  parameter int ROWS          = 8,
  parameter int BYTES_PER_ROW = 12,
  parameter int READ_LATENCY  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  oled_frame_streamer_if.master        bus
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
  localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(BYTES_PER_ROW - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          cap;
  logic          hs;

  logic [BYTES_PER_ROW-1:0][7:0] buf_q;

  // Valid is a pure function of state, so ready only gates the transition.
  assign hs = (state_q == S_SEND) && bus.byte_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          row_d   = '0;
          lat_d   = '0;
        end
      end
      S_READ: begin
        // Hold the address for READ_LATENCY+1 cycles; DataOut is valid in the last one.
        if (lat_q == LAT_LAST) begin
          cap     = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + 1'b1;
            lat_d   = '0;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
    end
  end

  // Row buffer is pure data: loaded only on the capture cycle, never reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      buf_q <= bus.mem_data_in;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.mem_we_bar = 1'b1;
  assign bus.mem_cs_bar = (state_q != S_READ);
  assign bus.mem_addr   = row_q;
  assign bus.byte_valid = (state_q == S_SEND);
  assign bus.byte_out   = (state_q == S_SEND) ? buf_q[idx_q] : 8'h00;
  assign bus.byte_last  = (state_q == S_SEND) && (row_q == ROW_LAST) && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_oled_frame_streamer.sv
module tb_oled_frame_streamer;

  localparam int NI   = 3;
  localparam int ROWS = 8;
  localparam int BPR  = 12;
  localparam int NB   = ROWS * BPR;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  // Hand-computed frame timing (relative to the cycle start is seen high).
  function automatic int fv_lit(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 5;
  endfunction
  function automatic int dn_lit(input int i);
    return (i == 0) ? 105 : (i == 1) ? 113 : 129;
  endfunction

  function automatic logic [7:0] exp_byte(input int n);
    return {1'b0, 3'(n / BPR), 4'(n % BPR)};
  endfunction

  function automatic logic [BPR-1:0][7:0] mem_word(input logic cs_bar, input logic [2:0] a);
    logic [BPR-1:0][7:0] w;
    for (int b = 0; b < BPR; b++) begin
      w[b] = cs_bar ? (8'hE5 ^ 8'(b)) : {1'b0, a, 4'(b)};
    end
    return w;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  logic req_idle, req_rst, req_frame, req_timing, req_timeout;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] busy_a, done_a, we_a, cs_a, vld_a, last_a;
  logic [7:0]    bo_a [NI];
  logic [2:0]    ad_a [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    oled_frame_streamer_if #(.ROWS(ROWS), .BYTES_PER_ROW(BPR)) ifc ();

    oled_frame_streamer #(.ROWS(ROWS), .BYTES_PER_ROW(BPR), .READ_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );

    logic       d_cs;
    logic [2:0] d_addr;

    if (LAT == 0) begin : g_comb
      assign d_cs   = ifc.mem_cs_bar;
      assign d_addr = ifc.mem_addr;
    end else begin : g_dly
      logic       cs_sr [LAT];
      logic [2:0] ad_sr [LAT];
      always @(posedge clk) begin
        cs_sr[0] <= ifc.mem_cs_bar;
        ad_sr[0] <= ifc.mem_addr;
        for (int j = 1; j < LAT; j++) begin
          cs_sr[j] <= cs_sr[j-1];
          ad_sr[j] <= ad_sr[j-1];
        end
      end
      assign d_cs   = cs_sr[LAT-1];
      assign d_addr = ad_sr[LAT-1];
    end

    assign ifc.mem_data_in = mem_word(d_cs, d_addr);
    assign ifc.start       = start;
    assign ifc.byte_ready  = ready;

    assign busy_a[g] = ifc.busy;
    assign done_a[g] = ifc.done;
    assign we_a[g]   = ifc.mem_we_bar;
    assign cs_a[g]   = ifc.mem_cs_bar;
    assign vld_a[g]  = ifc.byte_valid;
    assign last_a[g] = ifc.byte_last;
    assign bo_a[g]   = ifc.byte_out;
    assign ad_a[g]   = ifc.mem_addr;
  end

  // Behavioural model state: a frame is "active" from the cycle after start
  // until its done cycle; bytes are due from m_vfrom onwards.
  bit   m_act   [NI];
  int   m_n     [NI];
  int   m_vfrom [NI];
  int   m_done  [NI];
  int   m_k     [NI];
  int   obs_fv  [NI];
  int   obs_dn  [NI];
  int   done_cnt[NI];
  int   last_cnt[NI];
  int   last_idx[NI];
  int   rec_n   [NI];
  logic [7:0] rec [NI][NB];
  bit   e_v, e_cs;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (req_timeout) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout cyc%0d: frame did not finish within budget", cyc);
      end
      for (int i = 0; i < NI; i++) begin
        e_v  = m_act[i] && (cyc >= m_vfrom[i]) && (m_n[i] < NB);
        e_cs = m_act[i] && (m_n[i] < NB) && (cyc < m_vfrom[i]);

        chk("busy",   i, 32'(busy_a[i]), 32'(m_act[i]));
        chk("done",   i, 32'(done_a[i]), 32'(m_act[i] && m_n[i] == NB && cyc == m_done[i]));
        chk("we_bar", i, 32'(we_a[i]),   32'd1);
        chk("cs_bar", i, 32'(cs_a[i]),   32'(!e_cs));
        chk("valid",  i, 32'(vld_a[i]),  32'(e_v));
        chk("last",   i, 32'(last_a[i]), 32'(e_v && m_n[i] == NB - 1));
        if (e_v)  chk("byte", i, 32'(bo_a[i]), 32'(exp_byte(m_n[i])));
        if (e_cs) chk("addr", i, 32'(ad_a[i]), 32'(m_n[i] / BPR));

        if (vld_a[i] && obs_fv[i] < 0) obs_fv[i] = cyc;
        if (done_a[i]) begin
          done_cnt[i]++;
          obs_dn[i] = cyc;
        end
        if (vld_a[i] && ready) begin
          if (rec_n[i] < NB) rec[i][rec_n[i]] = bo_a[i];
          if (last_a[i]) begin
            last_cnt[i]++;
            last_idx[i] = rec_n[i];
          end
          rec_n[i]++;
        end

        if (req_idle) begin
          chk("idle_cs",    i, 32'(cs_a[i]),   32'd1);
          chk("idle_we",    i, 32'(we_a[i]),   32'd1);
          chk("idle_valid", i, 32'(vld_a[i]),  32'd0);
          chk("idle_busy",  i, 32'(busy_a[i]), 32'd0);
        end
        if (req_rst) begin
          chk("rst_busy",  i, 32'(busy_a[i]), 32'd0);
          chk("rst_done",  i, 32'(done_a[i]), 32'd0);
          chk("rst_we",    i, 32'(we_a[i]),   32'd1);
          chk("rst_cs",    i, 32'(cs_a[i]),   32'd1);
          chk("rst_addr",  i, 32'(ad_a[i]),   32'd0);
          chk("rst_byte",  i, 32'(bo_a[i]),   32'd0);
          chk("rst_valid", i, 32'(vld_a[i]),  32'd0);
          chk("rst_last",  i, 32'(last_a[i]), 32'd0);
        end
        if (req_frame) begin
          chk("frame_bytes", i, 32'(rec_n[i]),    32'd96);
          chk("byte0",       i, 32'(rec[i][0]),   32'h00);
          chk("byte11",      i, 32'(rec[i][11]),  32'h0B);
          chk("byte12",      i, 32'(rec[i][12]),  32'h10);
          chk("byte40",      i, 32'(rec[i][40]),  32'h34);
          chk("byte95",      i, 32'(rec[i][95]),  32'h7B);
          chk("done_count",  i, 32'(done_cnt[i]), 32'd1);
          chk("last_count",  i, 32'(last_cnt[i]), 32'd1);
          chk("last_index",  i, 32'(last_idx[i]), 32'd95);
        end
        if (req_timing) begin
          chk("first_valid_at", i, 32'(obs_fv[i] - m_k[i]), 32'(fv_lit(i)));
          chk("done_at",        i, 32'(obs_dn[i] - m_k[i]), 32'(dn_lit(i)));
        end

        if (rst) begin
          m_act[i] = 1'b0;
        end else if (m_act[i]) begin
          if (e_v && ready) begin
            m_n[i]++;
            if (m_n[i] == NB) m_done[i] = cyc + 1;
            else if (m_n[i] % BPR == 0) m_vfrom[i] = cyc + 2 + lat_of(i);
          end else if (m_n[i] == NB && cyc == m_done[i]) begin
            m_act[i] = 1'b0;
          end
        end else if (start) begin
          m_act[i]    = 1'b1;
          m_n[i]      = 0;
          m_vfrom[i]  = cyc + 2 + lat_of(i);
          m_k[i]      = cyc;
          m_done[i]   = -1;
          obs_fv[i]   = -1;
          obs_dn[i]   = -1;
          done_cnt[i] = 0;
          last_cnt[i] = 0;
          last_idx[i] = -1;
          rec_n[i]    = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int i = 0; i < NI; i++) if (m_act[i] || busy_a[i]) r = 1'b0;
    return r;
  endfunction

  // mode 0: ready high; 1: toggling ready with random stalls;
  // 2: start re-pulsed at byte 40; 3: reset mid-row-3 with valid high.
  task automatic run_frame(input int mode);
    int  stall = 0;
    int  t     = 0;
    bit  fired = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    while (t < 4000 && !all_idle()) begin
      if (mode == 1) begin
        if (stall > 0) begin
          ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 7) == 0) begin
          stall = $urandom_range(0, 5);
          ready = 1'b0;
        end else begin
          ready = ~ready;
        end
      end
      if (mode == 2 && !fired && m_n[1] == 40) begin
        start = 1'b1;
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (mode == 3 && !fired && m_n[1] == 40 && vld_a[1]) begin
        fired = 1'b1;
        rst   = 1'b1;
        tick();
        rst     = 1'b0;
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        t += 2;
      end else begin
        tick();
        t++;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (t >= 4000) begin
      req_timeout = 1'b1;
      tick();
      req_timeout = 1'b0;
    end
  endtask

  task automatic pulse_frame_check(input bit timing);
    req_frame  = 1'b1;
    req_timing = timing;
    tick();
    req_frame  = 1'b0;
    req_timing = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    ready       = 1'b0;
    req_idle    = 1'b0;
    req_rst     = 1'b0;
    req_frame   = 1'b0;
    req_timing  = 1'b0;
    req_timeout = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    req_idle = 1'b1;
    repeat (10) tick();
    req_idle = 1'b0;

    run_frame(0);
    pulse_frame_check(1'b1);

    run_frame(1);
    pulse_frame_check(1'b0);

    run_frame(2);
    repeat (3) tick();
    pulse_frame_check(1'b0);

    start = 1'b1;
    repeat (300) tick();
    start = 1'b0;
    begin
      int t = 0;
      while (t < 1000 && !all_idle()) begin
        tick();
        t++;
      end
      if (t >= 1000) begin
        req_timeout = 1'b1;
        tick();
        req_timeout = 1'b0;
      end
    end

    run_frame(3);
    run_frame(0);
    pulse_frame_check(1'b1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
